// File: rtl/if_next_pc_btb_if.sv
// IF next-PC / BTB bundle: pipeline stall, prediction and ID
// resolution inputs, fetch PC and redirect outputs.
interface if_next_pc_btb_if;
  logic        pc_stall;
  logic        brch_hazard_stall;
  logic        predict_br_taken;
  logic        brch_instr_detectd_ID;
  logic        actual_brch_result;
  logic [31:0] actual_brch_target;
  logic [31:0] pc_IF;
  logic        btb_hit_IF;
  logic        flush_IF;
  logic [15:0] mispredict_cnt;

  modport master (
    output pc_stall,
    output brch_hazard_stall,
    output predict_br_taken,
    output brch_instr_detectd_ID,
    output actual_brch_result,
    output actual_brch_target,
    input  pc_IF,
    input  btb_hit_IF,
    input  flush_IF,
    input  mispredict_cnt
  );

  modport slave (
    input  pc_stall,
    input  brch_hazard_stall,
    input  predict_br_taken,
    input  brch_instr_detectd_ID,
    input  actual_brch_result,
    input  actual_brch_target,
    output pc_IF,
    output btb_hit_IF,
    output flush_IF,
    output mispredict_cnt
  );
endinterface

// File: rtl/if_next_pc_btb.sv
// IF-stage next-PC generator with direct-mapped BTB; checks the
// IF prediction in ID and redirects with a one-cycle penalty.
module if_next_pc_btb #(
  parameter int unsigned BTB_ENTRIES = 16,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input logic            clk,
  input logic            rst_n,
  if_next_pc_btb_if.slave bus
);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  logic [BTB_ENTRIES-1:0] vld_q;
  logic [TAG_W-1:0]       tag_mem [BTB_ENTRIES];
  logic [29:0]            tgt_mem [BTB_ENTRIES];

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] pc4;
  logic        pred_q;
  logic [31:0] pc4_q;
  logic [31:0] tgt_q;
  logic [15:0] cnt_q;

  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [TAG_W-1:0] rd_tag;
  logic [TAG_W-1:0] wr_tag;
  logic [29:0]      br_pc;
  logic [31:0]      btb_tgt;
  logic             hit;
  logic             eff_pred;
  logic             upd;
  logic             mispred;
  logic             stall;
  logic             btb_we;

  assign rd_idx  = pc_q[IDX_W+1:2];
  assign rd_tag  = pc_q[31:IDX_W+2];
  // Word address of the branch now in ID, recovered from its PC+4.
  assign br_pc   = pc4_q[31:2] - 30'd1;
  assign wr_idx  = br_pc[IDX_W-1:0];
  assign wr_tag  = br_pc[29:IDX_W];
  assign btb_tgt = {tgt_mem[rd_idx], 2'b00};
  assign pc4     = pc_q + 32'd4;

  assign hit = rst_n & vld_q[rd_idx]
             & (tag_mem[rd_idx] == rd_tag);
  assign eff_pred = bus.predict_br_taken & hit;

  assign upd = bus.brch_instr_detectd_ID
             & ~bus.brch_hazard_stall;
  assign mispred = rst_n & upd & (
      (bus.actual_brch_result != pred_q)
    | (bus.actual_brch_result & pred_q
       & (bus.actual_brch_target != tgt_q)));
  assign btb_we = rst_n & upd & bus.actual_brch_result;
  assign stall  = bus.pc_stall | bus.brch_hazard_stall;

  always_comb begin
    pc_d = pc4;
    if (mispred) begin
      if (bus.actual_brch_result)
        pc_d = {bus.actual_brch_target[31:2], 2'b00};
      else
        pc_d = pc4_q;
    end else if (stall) begin
      pc_d = pc_q;
    end else if (eff_pred) begin
      pc_d = btb_tgt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q   <= RESET_PC;
      pred_q <= 1'b0;
      pc4_q  <= 32'd0;
      tgt_q  <= 32'd0;
      cnt_q  <= 16'd0;
      vld_q  <= '0;
    end else begin
      pc_q <= pc_d;
      if (mispred) begin
        pred_q <= 1'b0;
      end else if (!stall) begin
        pred_q <= eff_pred;
        pc4_q  <= pc4;
        tgt_q  <= btb_tgt;
      end
      if (mispred && cnt_q != 16'hFFFF)
        cnt_q <= cnt_q + 16'd1;
      if (btb_we)
        vld_q[wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (btb_we) begin
      tag_mem[wr_idx] <= wr_tag;
      tgt_mem[wr_idx] <= bus.actual_brch_target[31:2];
    end
  end

  assign bus.pc_IF          = pc_q;
  assign bus.btb_hit_IF     = hit;
  assign bus.flush_IF       = mispred;
  assign bus.mispredict_cnt = cnt_q;
endmodule

// File: tb/tb_if_next_pc_btb.sv
// Directed bench for if_next_pc_btb: reset, cold/warm BTB,
// mispredicts, aliasing, stalls, saturation, reset mid-flush.
module tb_if_next_pc_btb;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  if_next_pc_btb_if bus ();

  if_next_pc_btb #(
    .BTB_ENTRIES(16),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic id_set(input logic b, input logic r,
                        input logic [31:0] t);
    bus.brch_instr_detectd_ID = b;
    bus.actual_brch_result    = r;
    bus.actual_brch_target    = t;
  endtask

  task automatic walk_to(input logic [31:0] a);
    for (int i = 0; i < 64 && bus.pc_IF !== a; i++) tick();
    check("walk", bus.pc_IF, a);
  endtask

  // Taken resolution of a filler instruction two slots on,
  // used only to steer the fetch PC back to a target.
  task automatic redirect(input logic [31:0] t);
    tick();
    tick();
    id_set(1'b1, 1'b1, t);
    #1;
    tick();
    id_set(1'b0, 1'b0, 32'd0);
    #1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst_n = 1'b0;
    bus.pc_stall = 1'b0;
    bus.brch_hazard_stall = 1'b0;
    bus.predict_br_taken = 1'b0;
    id_set(1'b0, 1'b0, 32'd0);

    repeat (2) tick();
    check("rst_pc", bus.pc_IF, 32'h0);
    check("rst_hit", 32'(bus.btb_hit_IF), 32'h0);
    check("rst_flush", 32'(bus.flush_IF), 32'h0);
    check("rst_cnt", 32'(bus.mispredict_cnt), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rel_pc0", bus.pc_IF, 32'h0);
    tick();
    check("rel_pc4", bus.pc_IF, 32'h4);
    tick();
    check("rel_pc8", bus.pc_IF, 32'h8);
    check("rel_flush", 32'(bus.flush_IF), 32'h0);

    walk_to(32'h40);
    bus.predict_br_taken = 1'b1;
    #1;
    check("cold_hit", 32'(bus.btb_hit_IF), 32'h0);
    tick();
    check("cold_fall", bus.pc_IF, 32'h44);
    bus.predict_br_taken = 1'b0;
    id_set(1'b1, 1'b1, 32'h100);
    #1;
    check("cold_flush", 32'(bus.flush_IF), 32'h1);
    tick();
    check("cold_pc", bus.pc_IF, 32'h100);
    check("cold_cnt", 32'(bus.mispredict_cnt), 32'h1);
    id_set(1'b0, 1'b0, 32'd0);
    #1;

    redirect(32'h40);
    check("warm_pc0", bus.pc_IF, 32'h40);
    check("warm_cnt0", 32'(bus.mispredict_cnt), 32'h2);
    bus.predict_br_taken = 1'b1;
    #1;
    check("warm_hit", 32'(bus.btb_hit_IF), 32'h1);
    tick();
    check("warm_pc", bus.pc_IF, 32'h100);
    bus.predict_br_taken = 1'b0;
    id_set(1'b1, 1'b1, 32'h100);
    #1;
    check("warm_flush", 32'(bus.flush_IF), 32'h0);
    tick();
    check("warm_cnt", 32'(bus.mispredict_cnt), 32'h2);
    check("warm_seq", bus.pc_IF, 32'h104);
    id_set(1'b0, 1'b0, 32'd0);
    #1;

    redirect(32'h40);
    check("nt_cnt0", 32'(bus.mispredict_cnt), 32'h3);
    bus.predict_br_taken = 1'b1;
    #1;
    check("nt_hit", 32'(bus.btb_hit_IF), 32'h1);
    tick();
    check("nt_pred_pc", bus.pc_IF, 32'h100);
    bus.predict_br_taken = 1'b0;
    id_set(1'b1, 1'b0, 32'h0);
    #1;
    check("nt_flush", 32'(bus.flush_IF), 32'h1);
    tick();
    check("nt_pc", bus.pc_IF, 32'h44);
    check("nt_cnt", 32'(bus.mispredict_cnt), 32'h4);
    id_set(1'b0, 1'b0, 32'd0);
    #1;
    redirect(32'h40);
    check("nt_retain", 32'(bus.btb_hit_IF), 32'h1);
    check("nt_cnt2", 32'(bus.mispredict_cnt), 32'h5);

    walk_to(32'h48);
    check("pre_hit48", 32'(bus.btb_hit_IF), 32'h1);
    walk_to(32'h80);
    bus.predict_br_taken = 1'b1;
    #1;
    check("alias_hit", 32'(bus.btb_hit_IF), 32'h0);
    tick();
    check("alias_pc", bus.pc_IF, 32'h84);
    bus.predict_br_taken = 1'b0;
    bus.brch_hazard_stall = 1'b1;
    id_set(1'b1, 1'b1, 32'h200);
    #1;
    check("haz_flush", 32'(bus.flush_IF), 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("haz_pc", bus.pc_IF, 32'h84);
    end
    check("haz_cnt", 32'(bus.mispredict_cnt), 32'h5);
    bus.brch_hazard_stall = 1'b0;
    #1;
    check("haz_rel_flush", 32'(bus.flush_IF), 32'h1);
    tick();
    check("haz_rel_pc", bus.pc_IF, 32'h200);
    check("haz_rel_cnt", 32'(bus.mispredict_cnt), 32'h6);
    bus.pc_stall = 1'b1;
    id_set(1'b1, 1'b1, 32'h300);
    #1;
    check("stall_flush", 32'(bus.flush_IF), 32'h1);
    tick();
    check("stall_redir", bus.pc_IF, 32'h300);
    check("stall_cnt", 32'(bus.mispredict_cnt), 32'h7);
    bus.pc_stall = 1'b0;

    repeat (65528) tick();
    check("sat_reach", 32'(bus.mispredict_cnt), 32'hFFFF);
    check("sat_flush", 32'(bus.flush_IF), 32'h1);
    tick();
    check("sat_hold", 32'(bus.mispredict_cnt), 32'hFFFF);

    rst_n = 1'b0;
    #1;
    check("mid_flush", 32'(bus.flush_IF), 32'h0);
    tick();
    check("mid_pc", bus.pc_IF, 32'h0);
    check("mid_cnt", 32'(bus.mispredict_cnt), 32'h0);
    id_set(1'b0, 1'b0, 32'd0);
    rst_n = 1'b1;
    #1;
    walk_to(32'h48);
    check("mid_hit48", 32'(bus.btb_hit_IF), 32'h0);
    walk_to(32'h80);
    check("mid_hit80", 32'(bus.btb_hit_IF), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
